// File: rtl/unet_host_driver.sv
// Host-side initiator for one UNET inference: kicks ap_start over AXI-Lite, streams a frame in,
// drains the results and polls the control register until ap_done before pulsing done.
module unet_host_driver #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned IN_WORDS    = 12288,
  parameter int unsigned OUT_WORDS   = 12288,
  parameter int unsigned POLL_GAP    = 16
) (
  input  logic                   axi_clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   pix_valid,
  input  logic [11:0]            pix_data,
  output logic                   pix_ready,
  output logic                   res_valid,
  output logic [11:0]            res_data,
  input  logic                   res_ready,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic [3:0]             wstrb,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic [1:0]             ss_tuser,
  output logic [3:0]             ss_tstrb,
  output logic [3:0]             ss_tkeep,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tready
);

  localparam int unsigned InW  = $clog2(IN_WORDS + 1);
  localparam int unsigned OutW = $clog2(OUT_WORDS + 1);
  localparam int unsigned GapW = $clog2(POLL_GAP + 1);

  localparam logic [InW-1:0]  InMax   = InW'(IN_WORDS);
  localparam logic [InW-1:0]  InLast  = InW'(IN_WORDS - 1);
  localparam logic [OutW-1:0] OutMax  = OutW'(OUT_WORDS);
  localparam logic [GapW-1:0] GapLast = GapW'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StWrStart, StStream, StPollAr, StPollR, StGap, StDone
  } state_e;

  state_e                 state_q;
  logic [InW-1:0]         in_cnt_q;
  logic [OutW-1:0]        out_cnt_q;
  logic [GapW-1:0]        gap_cnt_q;
  logic                   aw_ok_q, w_ok_q;
  logic                   awvalid_q, wvalid_q, arvalid_q, rready_q, done_q;
  logic [pADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [pDATA_WIDTH-1:0] wdata_q;
  logic [3:0]             wstrb_q;

  logic streaming, in_open, out_open;
  logic aw_fire, w_fire;
  logic unused_bits;

  assign streaming = (state_q == StStream);
  // Counters saturate at their limit, which also closes the corresponding stream.
  assign in_open   = streaming && (in_cnt_q != InMax);
  assign out_open  = streaming && (out_cnt_q != OutMax);

  assign ss_tvalid = in_open && pix_valid;
  assign pix_ready = in_open && ss_tready;
  assign ss_tdata  = streaming ? {{(pDATA_WIDTH - 12){1'b0}}, pix_data} : '0;
  assign ss_tlast  = streaming && (in_cnt_q == InLast);
  assign ss_tuser  = 2'b00;
  assign ss_tstrb  = streaming ? 4'hF : 4'h0;
  assign ss_tkeep  = streaming ? 4'hF : 4'h0;

  assign res_valid = out_open && sm_tvalid;
  assign sm_tready = out_open && res_ready;
  assign res_data  = streaming ? sm_tdata[11:0] : 12'h000;

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign awvalid = awvalid_q;
  assign awaddr  = awaddr_q;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign rready  = rready_q;

  assign aw_fire = awvalid_q && awready;
  assign w_fire  = wvalid_q && wready;

  assign unused_bits = ^{rdata[pDATA_WIDTH-1:2], rdata[0], sm_tdata[pDATA_WIDTH-1:12]};

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      gap_cnt_q <= '0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          gap_cnt_q <= '0;
          aw_ok_q   <= 1'b0;
          w_ok_q    <= 1'b0;
          if (start) begin
            state_q   <= StWrStart;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            awaddr_q  <= '0;
            wdata_q   <= {{(pDATA_WIDTH - 1){1'b0}}, 1'b1};
            wstrb_q   <= 4'h1;
          end
        end
        StWrStart: begin
          // AW and W complete independently; each valid drops on its own handshake.
          if (aw_fire) begin
            awvalid_q <= 1'b0;
            aw_ok_q   <= 1'b1;
          end
          if (w_fire) begin
            wvalid_q <= 1'b0;
            w_ok_q   <= 1'b1;
          end
          if ((aw_ok_q || aw_fire) && (w_ok_q || w_fire)) begin
            state_q <= StStream;
            wdata_q <= '0;
            wstrb_q <= 4'h0;
          end
        end
        StStream: begin
          if (ss_tvalid && ss_tready) in_cnt_q <= in_cnt_q + 1'b1;
          if (res_valid && res_ready) out_cnt_q <= out_cnt_q + 1'b1;
          if ((in_cnt_q == InMax) && (out_cnt_q == OutMax)) begin
            state_q   <= StPollAr;
            arvalid_q <= 1'b1;
            araddr_q  <= '0;
          end
        end
        StPollAr: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StPollR;
          end
        end
        StPollR: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            if (rdata[1]) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q   <= StGap;
              gap_cnt_q <= '0;
            end
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            gap_cnt_q <= '0;
            arvalid_q <= 1'b1;
            state_q   <= StPollAr;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
